// File: rtl/am2925_wait_ctl.sv
// Am2925 cycle-side controller: decodes C1..C4 to find microcycle boundaries,
// drives the L1..L3 length code and runs the WAITREQ_/WAITACK_/READY_/CX wait handshake.
module am2925_wait_ctl #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNTW    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            c1,
   input  logic            c2,
   input  logic            c3,
   input  logic            c4,
   input  logic            waitack_,
   input  logic [3:0]      len,
   input  logic            mem_req,
   input  logic            mem_rdy,
   input  logic            err_clr,
   output logic            l1,
   output logic            l2,
   output logic            l3,
   output logic            waitreq_,
   output logic            ready_,
   output logic            cx,
   output logic            busy,
   output logic            timeout_err,
   output logic [CNTW-1:0] wait_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_REL  = 2'b11
   } state_t;

   localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
   localparam logic [CNTW-1:0] TO_VAL   = CNTW'(TIMEOUT);
   localparam logic [CNTW-1:0] REL_LAST = CNTW'(TIMEOUT - 1);
   localparam logic [3:0]      PH_FIRST = 4'b1110;

   // Generator length code {L3,L2,L1}; out-of-range requests clamp to 3 or 10.
   function automatic logic [2:0] enc_len(input logic [3:0] l);
      logic [2:0] code;
      case (l)
         4'd0, 4'd1, 4'd2, 4'd3: code = 3'b000;
         4'd4:                   code = 3'b001;
         4'd5:                   code = 3'b101;
         4'd6:                   code = 3'b111;
         4'd7:                   code = 3'b011;
         4'd8:                   code = 3'b010;
         4'd9:                   code = 3'b110;
         default:                code = 3'b100;
      endcase
      return code;
   endfunction

   state_t          state_q, state_d;
   logic [3:0]      cprev_q, cprev_d;
   logic [2:0]      lcode_q, lcode_d;
   logic            waitreq_q, waitreq_d;
   logic            ready_q, ready_d;
   logic            cx_q, cx_d;
   logic            busy_q, busy_d;
   logic            err_q, err_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [CNTW-1:0] rel_q, rel_d;
   logic [3:0]      phase_s;
   logic            boundary_s;
   logic            to_set_s;
   logic [CNTW-1:0] cnt_inc_s;
   logic [CNTW-1:0] rel_inc_s;

   // Next-state logic for phase tracking, length code and the wait handshake.
   always_comb begin
      phase_s    = {c1, c2, c3, c4};
      boundary_s = (phase_s == PH_FIRST) && (cprev_q != PH_FIRST);
      cprev_d    = phase_s;
      state_d    = state_q;
      waitreq_d  = waitreq_q;
      ready_d    = ready_q;
      cx_d       = cx_q;
      cnt_d      = cnt_q;
      rel_d      = rel_q;
      to_set_s   = 1'b0;

      if (boundary_s) begin
         lcode_d = enc_len(len);
      end else begin
         lcode_d = lcode_q;
      end

      if (cnt_q == CNT_MAX) begin
         cnt_inc_s = cnt_q;
      end else begin
         cnt_inc_s = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
      end
      if (rel_q == CNT_MAX) begin
         rel_inc_s = rel_q;
      end else begin
         rel_inc_s = rel_q + {{(CNTW-1){1'b0}}, 1'b1};
      end

      case (state_q)
         ST_IDLE: begin
            waitreq_d = 1'b1;
            ready_d   = 1'b1;
            cx_d      = 1'b1;
            if (boundary_s && mem_req && !mem_rdy) begin
               state_d   = ST_REQ;
               waitreq_d = 1'b0;
               cx_d      = 1'b0;
               cnt_d     = {CNTW{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            cnt_d = cnt_inc_s;
            if (mem_rdy || !mem_req) begin
               state_d   = ST_REL;
               waitreq_d = 1'b1;
               ready_d   = 1'b0;
               rel_d     = {CNTW{1'b0}};
            end else if (!waitack_) begin
               state_d   = ST_WAIT;
               waitreq_d = 1'b1;
            end else begin
               waitreq_d = 1'b0;
            end
         end
         ST_WAIT: begin
            cx_d  = 1'b0;
            cnt_d = cnt_inc_s;
            if (mem_rdy || !mem_req) begin
               state_d = ST_REL;
               ready_d = 1'b0;
               rel_d   = {CNTW{1'b0}};
            end else if (cnt_q >= TO_VAL) begin
               state_d  = ST_REL;
               ready_d  = 1'b0;
               rel_d    = {CNTW{1'b0}};
               to_set_s = 1'b1;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_REL: begin
            ready_d   = 1'b0;
            waitreq_d = 1'b1;
            rel_d     = rel_inc_s;
            // A generator that never lifts WAITACK_ must not hold READY_ forever.
            if (waitack_ || (rel_q >= REL_LAST)) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
               cx_d    = 1'b1;
            end else begin
               state_d = ST_REL;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            waitreq_d = 1'b1;
            ready_d   = 1'b1;
            cx_d      = 1'b1;
         end
      endcase

      busy_d = (state_d != ST_IDLE);

      if (to_set_s) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // State and output registers; reset releases the generator via cx=1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cprev_q   <= 4'b0000;
         lcode_q   <= 3'b100;
         waitreq_q <= 1'b1;
         ready_q   <= 1'b1;
         cx_q      <= 1'b1;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= {CNTW{1'b0}};
         rel_q     <= {CNTW{1'b0}};
      end else begin
         state_q   <= state_d;
         cprev_q   <= cprev_d;
         lcode_q   <= lcode_d;
         waitreq_q <= waitreq_d;
         ready_q   <= ready_d;
         cx_q      <= cx_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         rel_q     <= rel_d;
      end
   end

   assign {l3, l2, l1} = lcode_q;
   assign waitreq_     = waitreq_q;
   assign ready_       = ready_q;
   assign cx           = cx_q;
   assign busy         = busy_q;
   assign timeout_err  = err_q;
   assign wait_cnt     = cnt_q;

endmodule
